// File: rtl/note_hit_judge.sv
// rtl/note_hit_judge.sv - per-lane rhythm-game note hit judge with debounced buttons
//
// Judges button presses against notes in the strike zone, one lane per bit.
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   en_i           judging enable; low freezes lane FSMs and counters, drops presses
//   btn_i          raw asynchronous lane buttons, active-high
//   note_i         per-lane note-in-zone level
//   hit_pulse_o    one-cycle pulse per lane on a successful hit
//   miss_pulse_o   one-cycle pulse per lane when a note leaves the zone unhit
//   stray_pulse_o  one-cycle pulse per lane on a press with no note present
//   score_o        total hits, saturating
//   combo_o        consecutive hits since the last miss or stray, saturating
//   miss_cnt_o     total misses, saturating
module note_hit_judge #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LANES           = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [LANES-1:0] btn_i,
    input  logic [LANES-1:0] note_i,
    output logic [LANES-1:0] hit_pulse_o,
    output logic [LANES-1:0] miss_pulse_o,
    output logic [LANES-1:0] stray_pulse_o,
    output logic [15:0]      score_o,
    output logic [7:0]       combo_o,
    output logic [7:0]       miss_cnt_o
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } lane_state_t;

    logic [LANES-1:0] btn_s1;
    logic [LANES-1:0] btn_s2;
    logic [LANES-1:0] deb;
    logic [LANES-1:0] deb_prev;
    logic [LANES-1:0] press;
    logic [LANES-1:0] note_r;
    logic [CW-1:0]    db_cnt [LANES];

    lane_state_t      state    [LANES];
    lane_state_t      state_nx [LANES];
    logic [LANES-1:0] hit_d;
    logic [LANES-1:0] miss_d;
    logic [LANES-1:0] stray_d;
    logic [7:0]       hit_n;
    logic [7:0]       miss_n;
    logic [16:0]      score_sum;
    logic [8:0]       combo_sum;
    logic [8:0]       miss_sum;
    logic [15:0]      score_nx;
    logic [7:0]       combo_nx;
    logic [7:0]       miss_cnt_nx;

    // Input conditioning. The debounced level only flips after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; press is the registered rising edge of
    // the debounced level, so it is a single-cycle event per accepted press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            deb      <= '0;
            deb_prev <= '0;
            press    <= '0;
            note_r   <= '0;
            for (int i = 0; i < LANES; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            btn_s1   <= btn_i;
            btn_s2   <= btn_s1;
            note_r   <= note_i;
            deb_prev <= deb;
            press    <= deb & ~deb_prev;
            for (int i = 0; i < LANES; i++) begin
                if (btn_s2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= btn_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Lane decisions and saturating counter arithmetic.
    always_comb begin
        hit_d   = '0;
        miss_d  = '0;
        stray_d = '0;
        hit_n   = '0;
        miss_n  = '0;
        for (int i = 0; i < LANES; i++) begin
            state_nx[i] = state[i];
            case (state[i])
                EMPTY: begin
                    if (press[i]) begin
                        stray_d[i] = 1'b1;
                    end else if (note_r[i]) begin
                        state_nx[i] = PENDING;
                    end
                end
                PENDING: begin
                    // A press landing as the note leaves still counts as a hit.
                    if (press[i]) begin
                        hit_d[i]    = 1'b1;
                        state_nx[i] = note_r[i] ? DONE : EMPTY;
                    end else if (!note_r[i]) begin
                        miss_d[i]   = 1'b1;
                        state_nx[i] = EMPTY;
                    end
                end
                DONE: begin
                    if (!note_r[i]) begin
                        state_nx[i] = EMPTY;
                    end
                end
                default: state_nx[i] = EMPTY;
            endcase
            hit_n  = hit_n + 8'(hit_d[i]);
            miss_n = miss_n + 8'(miss_d[i]);
        end

        score_sum   = {1'b0, score_o} + 17'(hit_n);
        combo_sum   = {1'b0, combo_o} + 9'(hit_n);
        miss_sum    = {1'b0, miss_cnt_o} + 9'(miss_n);
        score_nx    = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        miss_cnt_nx = miss_sum[8] ? 8'hFF : miss_sum[7:0];
        // Any break in any lane resets the combo, even if another lane hit.
        if ((miss_d | stray_d) != '0) begin
            combo_nx = 8'd0;
        end else begin
            combo_nx = combo_sum[8] ? 8'hFF : combo_sum[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LANES; i++) begin
                state[i] <= EMPTY;
            end
            hit_pulse_o   <= '0;
            miss_pulse_o  <= '0;
            stray_pulse_o <= '0;
            score_o       <= '0;
            combo_o       <= '0;
            miss_cnt_o    <= '0;
        end else if (en_i) begin
            for (int i = 0; i < LANES; i++) begin
                state[i] <= state_nx[i];
            end
            hit_pulse_o   <= hit_d;
            miss_pulse_o  <= miss_d;
            stray_pulse_o <= stray_d;
            score_o       <= score_nx;
            combo_o       <= combo_nx;
            miss_cnt_o    <= miss_cnt_nx;
        end else begin
            hit_pulse_o   <= '0;
            miss_pulse_o  <= '0;
            stray_pulse_o <= '0;
        end
    end

endmodule

// File: tb/tb_note_hit_judge.sv
// tb/tb_note_hit_judge.sv - scoreboard bench for note_hit_judge against a reference model
module tb_note_hit_judge;

    localparam int D = 4;
    localparam int L = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] btn = '0;
    logic [3:0] note = '0;
    logic [3:0] hit, miss, stray;
    logic [15:0] score;
    logic [7:0]  combo, misses;

    note_hit_judge #(.DEBOUNCE_CYCLES(D), .LANES(L)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .btn_i(btn), .note_i(note),
        .hit_pulse_o(hit), .miss_pulse_o(miss), .stray_pulse_o(stray),
        .score_o(score), .combo_o(combo), .miss_cnt_o(misses)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         stamp;
        logic [3:0] hit;
        logic [3:0] miss;
        logic [3:0] stray;
        int         score;
        int         combo;
        int         misses;
    } exp_t;

    exp_t sbq[$];
    int   nchecks = 0;
    int   nerr = 0;
    int   cyc = 0;

    int        m_state [L];
    bit        m_deb   [L];
    bit [15:0] m_hist  [L];
    bit [1:0]  m_pd    [L];
    bit        m_note  [L];
    int        m_score = 0;
    int        m_combo = 0;
    int        m_miss  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model, one step per clock edge. The button's debounced level
    // changes once the last D synchronized samples all disagree with it; a
    // rising change is judged two edges later against the note seen one edge back.
    initial begin : model_p
        logic [3:0] h, m, s;
        int         nh, nm;
        bit         pr, flip;
        exp_t       e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                for (int l = 0; l < L; l++) begin
                    m_state[l] = 0; m_deb[l] = 0; m_hist[l] = '0; m_pd[l] = '0; m_note[l] = 0;
                end
                m_score = 0; m_combo = 0; m_miss = 0;
            end else begin
                h = '0; m = '0; s = '0;
                if (en) begin
                    for (int l = 0; l < L; l++) begin
                        pr = m_pd[l][1];
                        case (m_state[l])
                            0: if (pr) s[l] = 1'b1; else if (m_note[l]) m_state[l] = 1;
                            1: if (pr) begin
                                   h[l] = 1'b1;
                                   m_state[l] = m_note[l] ? 2 : 0;
                               end else if (!m_note[l]) begin
                                   m[l] = 1'b1;
                                   m_state[l] = 0;
                               end
                            default: if (!m_note[l]) m_state[l] = 0;
                        endcase
                    end
                    nh = $countones(h);
                    nm = $countones(m);
                    m_score = (m_score + nh > 65535) ? 65535 : m_score + nh;
                    m_miss  = (m_miss + nm > 255) ? 255 : m_miss + nm;
                    if ((m | s) != '0) m_combo = 0;
                    else m_combo = (m_combo + nh > 255) ? 255 : m_combo + nh;
                    if ((h | m | s) != '0) begin
                        e.stamp = cyc; e.hit = h; e.miss = m; e.stray = s;
                        e.score = m_score; e.combo = m_combo; e.misses = m_miss;
                        sbq.push_back(e);
                    end
                end
                for (int l = 0; l < L; l++) begin
                    m_hist[l] = {m_hist[l][14:0], btn[l]};
                    flip = 1'b1;
                    for (int k = 2; k <= D + 1; k++) begin
                        if (m_hist[l][k] == m_deb[l]) flip = 1'b0;
                    end
                    if (flip) m_deb[l] = !m_deb[l];
                    m_pd[l] = {m_pd[l][0], flip && m_deb[l]};
                    m_note[l] = note[l];
                end
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT shows any pulse.
    initial begin : monitor_p
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].stamp < cyc) begin
                nchecks++;
                nerr++;
                $display("FAIL sb_missing: actual no pulse, expected hit=%b miss=%b stray=%b at cycle %0d",
                         sbq[0].hit, sbq[0].miss, sbq[0].stray, sbq[0].stamp);
                void'(sbq.pop_front());
            end
            if ((hit | miss | stray) != '0) begin
                if (sbq.size() == 0) begin
                    nchecks++;
                    nerr++;
                    $display("FAIL sb_unexpected: actual hit=%b miss=%b stray=%b at cycle %0d, expected no pulse",
                             hit, miss, stray, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("sb_cycle", cyc, e.stamp);
                    check("sb_pulses", {hit, miss, stray}, {e.hit, e.miss, e.stray});
                    check("sb_score", score, e.score);
                    check("sb_combo", combo, e.combo);
                    check("sb_misses", misses, e.misses);
                end
            end
            check("cnt_score", score, m_score);
            check("cnt_combo", combo, m_combo);
            check("cnt_misses", misses, m_miss);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hit_round(input logic [3:0] mask);
        note = note | mask;
        tick(2);
        btn = btn | mask;
        tick(9);
        btn = btn & ~mask;
        note = note & ~mask;
        tick(8);
    endtask

    initial begin : main_p
        int s0, found, sc, r;
        int bt [L];
        int nt [L];
        int et;

        rst = 1'b1;
        en = 1'b0;
        tick(3);
        check("reset_outputs", {hit, miss, stray, score, combo, misses}, 0);
        rst = 1'b0;
        en = 1'b1;
        tick(2);

        // First-press latency on lane 0.
        note[0] = 1'b1;
        btn[0] = 1'b1;
        s0 = cyc + 1;
        found = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (hit[0] && found < 0) found = cyc;
        end
        check("hit_latency", found, s0 + 7);
        check("hit_score", score, 1);
        check("hit_combo", combo, 1);
        btn = '0;
        note = '0;
        tick(10);

        // Unhit note on lane 2.
        note[2] = 1'b1;
        tick(20);
        note[2] = 1'b0;
        tick(6);
        check("miss_cnt", misses, 1);
        check("miss_combo", combo, 0);
        check("miss_score", score, 1);

        // Short glitch on lane 1 with a note present.
        note[1] = 1'b1;
        tick(3);
        btn[1] = 1'b1;
        tick(3);
        btn[1] = 1'b0;
        tick(12);
        check("glitch_score", score, 1);
        check("glitch_misses", misses, 1);
        note[1] = 1'b0;
        tick(6);

        // Combo of five, then a hit on lane 0 together with a stray on lane 3.
        repeat (5) hit_round(4'b0001);
        check("combo_five", combo, 5);
        sc = score;
        note[0] = 1'b1;
        tick(2);
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        found = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (hit[0] && found == 0) begin
                found = 1;
                check("stray_same_cycle", stray[3], 1);
            end
        end
        check("stray_hit_seen", found, 1);
        check("stray_combo", combo, 0);
        check("stray_score", score, sc + 1);
        btn = '0;
        note = '0;
        tick(8);

        // All four lanes at once, then a re-press while DONE.
        sc = score;
        note = 4'hF;
        tick(2);
        btn = 4'hF;
        found = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (hit != '0 && found == 0) begin
                found = 1;
                check("quad_hit", hit, 4'b1111);
            end
        end
        check("quad_hit_seen", found, 1);
        check("quad_score", score, sc + 4);
        btn = '0;
        tick(8);
        btn = 4'hF;
        tick(12);
        btn = '0;
        note = '0;
        tick(8);
        check("repress_score", score, sc + 4);

        // Reset while lane 1 is pending and its debouncer is mid-count.
        note[1] = 1'b1;
        tick(2);
        btn[1] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        r = cyc;
        check("rst_outputs", {hit, miss, stray, score, combo, misses}, 0);
        rst = 1'b0;
        found = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if ((hit | miss | stray) != '0 && found < 0) found = cyc;
        end
        check("rst_fresh_hit", found, r + 8);
        check("rst_fresh_score", score, 1);
        btn = '0;
        note = '0;
        tick(8);

        // Saturation of combo and miss counter.
        sc = score;
        repeat (70) hit_round(4'hF);
        check("combo_sat", combo, 255);
        check("combo_sat_score", score, sc + 280);
        repeat (70) begin
            note = 4'hF;
            tick(3);
            note = '0;
            tick(3);
        end
        check("miss_sat", misses, 255);
        check("miss_sat_combo", combo, 0);

        // Randomized traffic with enable gaps and a mid-run reset.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int l = 0; l < L; l++) begin
            bt[l] = 0;
            nt[l] = 0;
        end
        et = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = (c == 1500);
            for (int l = 0; l < L; l++) begin
                if (bt[l] == 0) begin
                    btn[l] = ~btn[l];
                    bt[l] = btn[l] ? $urandom_range(1, 14) : $urandom_range(1, 10);
                end else begin
                    bt[l]--;
                end
                if (nt[l] == 0) begin
                    note[l] = ~note[l];
                    nt[l] = note[l] ? $urandom_range(2, 25) : $urandom_range(1, 15);
                end else begin
                    nt[l]--;
                end
            end
            if (et == 0) begin
                en = ($urandom_range(0, 9) != 0);
                et = $urandom_range(5, 40);
            end else begin
                et--;
            end
            tick(1);
        end
        rst = 1'b0;
        en = 1'b1;
        btn = '0;
        note = '0;
        tick(20);
        check("sb_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
